// File: rtl/simplez_tx_port.sv
// SIMPLEZ memory-mapped UART transmitter: 8N1 by default, 8E1 when SIMPLEZ_TX_PARITY_EN is defined.
// State advances on the falling clock edge, in step with the CPU datapath.
module simplez_tx_port #(
  parameter int DATAW       = 12,
  parameter int ADDRW       = 9,
  parameter int ADDR_STATUS = 508,
  parameter int ADDR_DATA   = 509,
  parameter int CLK_DIV     = 104
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [ADDRW-1:0] addr,
  input  logic [DATAW-1:0] data_in,
  input  logic             wr,
  input  logic             rd,
  output logic [DATAW-1:0] data_out,
  output logic             tx,
  output logic             ready
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  localparam logic [ADDRW-1:0] STATUS_A  = ADDRW'(ADDR_STATUS);
  localparam logic [ADDRW-1:0] DATA_A    = ADDRW'(ADDR_DATA);
  localparam logic [15:0]      BAUD_LAST = 16'(CLK_DIV - 1);

  logic [2:0]  state_r, state_s;
  logic [15:0] baud_r, baud_s;
  logic [2:0]  bit_r, bit_s;
  logic [7:0]  shift_r, shift_s;
  logic        tx_r, tx_s;
  logic        ready_r, ready_s;
  logic        bit_end_s;
  logic        accept_s;
  logic        unused_s;
`ifdef SIMPLEZ_TX_PARITY_EN
  logic        par_r, par_s;
`endif

  assign unused_s = ^data_in[DATAW-1:8];

  // Zero-latency status read; everything else reads as the bus default.
  assign data_out = (rd && (addr == STATUS_A)) ? {{(DATAW-1){1'b0}}, ready_r} : {DATAW{1'b1}};
  assign tx       = tx_r;
  assign ready    = ready_r;

  // Next-state logic. The end of the stop bit also accepts a write so frames can abut.
  always_comb begin
    state_s   = state_r;
    baud_s    = baud_r;
    bit_s     = bit_r;
    shift_s   = shift_r;
    tx_s      = tx_r;
    ready_s   = ready_r;
`ifdef SIMPLEZ_TX_PARITY_EN
    par_s     = par_r;
`endif
    bit_end_s = (baud_r == BAUD_LAST);
    accept_s  = wr && (addr == DATA_A) && (ready_r || ((state_r == ST_STOP) && bit_end_s));
    if (accept_s) begin
      shift_s = data_in[7:0];
`ifdef SIMPLEZ_TX_PARITY_EN
      par_s   = ^data_in[7:0];
`endif
      tx_s    = 1'b0;
      state_s = ST_START;
      ready_s = 1'b0;
      baud_s  = 16'd0;
      bit_s   = 3'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          baud_s  = 16'd0;
          bit_s   = 3'd0;
          tx_s    = 1'b1;
          ready_s = 1'b1;
        end
        ST_START: begin
          if (bit_end_s) begin
            state_s = ST_DATA;
            baud_s  = 16'd0;
            tx_s    = shift_r[0];
          end else begin
            baud_s = baud_r + 16'd1;
          end
        end
        ST_DATA: begin
          if (!bit_end_s) begin
            baud_s = baud_r + 16'd1;
          end else if (bit_r == 3'd7) begin
            baud_s = 16'd0;
`ifdef SIMPLEZ_TX_PARITY_EN
            state_s = ST_PARITY;
            tx_s    = par_r;
`else
            state_s = ST_STOP;
            tx_s    = 1'b1;
`endif
          end else begin
            baud_s  = 16'd0;
            bit_s   = bit_r + 3'd1;
            shift_s = {1'b0, shift_r[7:1]};
            tx_s    = shift_r[1];
          end
        end
        ST_PARITY: begin
          if (bit_end_s) begin
            state_s = ST_STOP;
            baud_s  = 16'd0;
            tx_s    = 1'b1;
          end else begin
            baud_s = baud_r + 16'd1;
          end
        end
        ST_STOP: begin
          if (bit_end_s) begin
            state_s = ST_IDLE;
            baud_s  = 16'd0;
            bit_s   = 3'd0;
            ready_s = 1'b1;
          end else begin
            baud_s = baud_r + 16'd1;
          end
        end
        default: begin
          state_s = ST_IDLE;
          baud_s  = 16'd0;
          bit_s   = 3'd0;
          tx_s    = 1'b1;
          ready_s = 1'b1;
        end
      endcase
    end
  end

  // State registers on the falling edge; reset drops any frame in flight.
  always_ff @(negedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      baud_r  <= 16'd0;
      bit_r   <= 3'd0;
      shift_r <= 8'd0;
      tx_r    <= 1'b1;
      ready_r <= 1'b1;
`ifdef SIMPLEZ_TX_PARITY_EN
      par_r   <= 1'b0;
`endif
    end else begin
      state_r <= state_s;
      baud_r  <= baud_s;
      bit_r   <= bit_s;
      shift_r <= shift_s;
      tx_r    <= tx_s;
      ready_r <= ready_s;
`ifdef SIMPLEZ_TX_PARITY_EN
      par_r   <= par_s;
`endif
    end
  end

endmodule

// File: tb/tb_simplez_tx_port.sv
// Bench for simplez_tx_port: frame-level reference model (expected line as a queue of per-cycle bits).
module tb_simplez_tx_port;
  localparam int D = 4;
`ifdef SIMPLEZ_TX_PARITY_EN
  localparam int FL_CYC = 44;
`else
  localparam int FL_CYC = 40;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [8:0]  addr = 9'd0;
  logic [11:0] data_in = 12'd0;
  logic        wr = 1'b0;
  logic        rd = 1'b0;
  logic [11:0] data_out;
  logic        tx;
  logic        ready;

  int tests = 0;
  int failed = 0;
  bit chk_en = 1'b0;
  bit exp_line[$];
  bit cap[$];
  int low_cnt = 0;
  logic        last_tx;
  logic        last_rdy;
  logic [11:0] last_dout;

  simplez_tx_port #(.CLK_DIV(D)) dut (
    .clk(clk), .rst(rst), .addr(addr), .data_in(data_in), .wr(wr), .rd(rd),
    .data_out(data_out), .tx(tx), .ready(ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One bus cycle: drive after the rising edge, compare against the model, then let the falling edge act.
  task automatic step(input logic r, input logic w, input logic rdi, input logic [8:0] a, input logic [11:0] d);
    logic        e_tx;
    logic        e_rdy;
    logic [11:0] e_dout;
    @(posedge clk);
    rst = r; wr = w; rd = rdi; addr = a; data_in = d;
    #1;
    e_tx   = (exp_line.size() > 0) ? exp_line[0] : 1'b1;
    e_rdy  = (exp_line.size() == 0);
    e_dout = (rdi && a == 9'd508) ? {11'd0, e_rdy} : 12'hFFF;
    last_tx = tx; last_rdy = ready; last_dout = data_out;
    if (chk_en) begin
      check("tx", {11'd0, tx}, {11'd0, e_tx});
      check("ready", {11'd0, ready}, {11'd0, e_rdy});
      check("data_out", data_out, e_dout);
    end
    cap.push_back(tx);
    if (ready !== 1'b1) low_cnt++;
    @(negedge clk);
    if (r) begin
      exp_line.delete();
      chk_en = 1'b1;
    end else begin
      if (exp_line.size() > 0) void'(exp_line.pop_front());
      if (exp_line.size() == 0 && w && a == 9'd509) begin
        repeat (D) exp_line.push_back(1'b0);
        for (int i = 0; i < 8; i++) repeat (D) exp_line.push_back(d[i]);
`ifdef SIMPLEZ_TX_PARITY_EN
        repeat (D) exp_line.push_back(^d[7:0]);
`endif
        repeat (D) exp_line.push_back(1'b1);
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 9'd0, 12'd0);
  endtask

  task automatic wr_data(input logic [11:0] d);
    step(1'b0, 1'b1, 1'b0, 9'd509, d);
    cap.delete();
    low_cnt = 0;
  endtask

  // Compare captured line against a hand-written frame for 0x55.
  task automatic check_frame_55();
    logic [10:0] pat;
`ifdef SIMPLEZ_TX_PARITY_EN
    pat = 11'b10010101010;
`else
    pat = 11'b01010101010;
`endif
    for (int k = 0; k < FL_CYC; k++) begin
      if (k < cap.size()) check("frame55_bit", {11'd0, cap[k]}, {11'd0, pat[k / D]});
      else check("frame55_len", 12'd0, 12'd1);
    end
  endtask

  initial begin
    step(1'b1, 1'b0, 1'b0, 9'd0, 12'd0);
    step(1'b1, 1'b0, 1'b0, 9'd0, 12'd0);

    // 1: idle state and read map
    idle(20);
    check("s1_tx_idle", {11'd0, last_tx}, 12'd1);
    check("s1_ready_idle", {11'd0, last_rdy}, 12'd1);
    step(1'b0, 1'b0, 1'b1, 9'd508, 12'd0);
    check("s1_status", last_dout, 12'h001);
    step(1'b0, 1'b0, 1'b1, 9'd100, 12'd0);
    check("s1_unmapped", last_dout, 12'hFFF);

    // 2: single frame of 0x55
    wr_data(12'hA55);
    idle(10);
    step(1'b0, 1'b0, 1'b1, 9'd508, 12'd0);
    check("s2_status_busy", last_dout, 12'h000);
    idle(FL_CYC - 11 + 5);
    check_frame_55();
    check("s2_busy_len", 12'(low_cnt), 12'(FL_CYC));

    // 3: write while busy is dropped
    wr_data(12'hA55);
    idle(9);
    step(1'b0, 1'b1, 1'b0, 9'd509, 12'h0FF);
    idle(FL_CYC - 10 + 5);
    check_frame_55();
    check("s3_busy_len", 12'(low_cnt), 12'(FL_CYC));

    // 4: back-to-back frames
    wr_data(12'h041);
    idle(FL_CYC - 1);
    step(1'b0, 1'b1, 1'b0, 9'd509, 12'h042);
    idle(FL_CYC + 5);
    check("s4_busy_len", 12'(low_cnt), 12'(2 * FL_CYC));
    check("s4_last_stop", {11'd0, cap[FL_CYC-1]}, 12'd1);
    check("s4_next_start", {11'd0, cap[FL_CYC]}, 12'd0);

    // 5: reset mid-frame then clean frame
    wr_data(12'h05A);
    idle(16);
    step(1'b1, 1'b0, 1'b0, 9'd0, 12'd0);
    idle(1);
    check("s5_tx_after_rst", {11'd0, last_tx}, 12'd1);
    check("s5_ready_after_rst", {11'd0, last_rdy}, 12'd1);
    wr_data(12'h000);
    idle(FL_CYC + 3);
    check("s5_busy_len", 12'(low_cnt), 12'(FL_CYC));

`ifdef SIMPLEZ_TX_PARITY_EN
    // 6: parity bit values
    wr_data(12'h007);
    idle(FL_CYC + 2);
    check("s6_par_07", {11'd0, cap[9*D+1]}, 12'd1);
    wr_data(12'h003);
    idle(FL_CYC + 2);
    check("s6_par_03", {11'd0, cap[9*D+1]}, 12'd0);
`endif

    // Randomized traffic checked cycle by cycle against the model
    for (int i = 0; i < 1500; i++) begin
      logic       r;
      logic       w;
      logic       rr;
      logic [8:0] a;
      r  = ($urandom_range(0, 299) == 0);
      w  = ($urandom_range(0, 3) == 0);
      rr = $urandom_range(0, 1) == 1;
      case ($urandom_range(0, 3))
        0:       a = 9'd508;
        1, 2:    a = 9'd509;
        default: a = 9'($urandom);
      endcase
      step(r, w, rr, a, 12'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
